// File: rtl/quotient_rx_bcd.sv
// Serial quotient receiver: MSB-first frame deshifted straight into BCD
// digits via shift-add-3, reported as excess-coded digits with length check.
module quotient_rx_bcd #(
    parameter int BITS   = 10,
    parameter int DIGITS = 4,
    parameter int EXCESS = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    input  logic                  in_data,
    output logic                  out_valid,
    output logic [4*DIGITS-1:0]   out_data,
    output logic                  out_div0,
    output logic                  out_err
);

    localparam int DW = 4 * DIGITS;
    localparam int CW = $clog2(BITS + 2);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_FULL = CW'(BITS);
    localparam logic [CW-1:0] CNT_SAT  = CW'(BITS + 1);
    localparam logic [3:0]    EXC      = 4'(EXCESS);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [DW-1:0]   bcd_q, bcd_d;
    logic [BITS-1:0] bin_q, bin_d;

    logic            out_valid_q, out_valid_d;
    logic [DW-1:0]   out_data_q, out_data_d;
    logic            out_div0_q, out_div0_d;
    logic            out_err_q, out_err_d;

    logic [DW-1:0]   bcd_adj;
    logic [DW-1:0]   bcd_exc;

    function automatic logic [3:0] add3(input logic [3:0] d);
        return (d >= 4'd5) ? d + 4'd3 : d;
    endfunction

    // Per-digit pre-shift correction and the excess-coded output view.
    always_comb begin
        bcd_adj = '0;
        bcd_exc = '0;
        for (int i = 0; i < DIGITS; i++) begin
            bcd_adj[4*i +: 4] = add3(bcd_q[4*i +: 4]);
            bcd_exc[4*i +: 4] = bcd_q[4*i +: 4] + EXC;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bcd_d       = bcd_q;
        bin_d       = bin_q;
        out_valid_d = 1'b0;
        out_data_d  = '0;
        out_div0_d  = 1'b0;
        out_err_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    bcd_d   = {{(DW-1){1'b0}}, in_data};
                    bin_d   = {{(BITS-1){1'b0}}, in_data};
                    cnt_d   = CNT_ONE;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (in_valid) begin
                    bcd_d = {bcd_adj[DW-2:0], in_data};
                    bin_d = {bin_q[BITS-2:0], in_data};
                    if (cnt_q != CNT_SAT) begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end else begin
                    if (cnt_q == CNT_FULL) begin
                        out_valid_d = 1'b1;
                        out_data_d  = bcd_exc;
                        out_div0_d  = &bin_q;
                    end else begin
                        out_err_d   = 1'b1;
                    end
                    state_d = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            bcd_q       <= '0;
            bin_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_div0_q  <= 1'b0;
            out_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bcd_q       <= bcd_d;
            bin_q       <= bin_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_div0_q  <= out_div0_d;
            out_err_q   <= out_err_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_div0  = out_div0_q;
    assign out_err   = out_err_q;

endmodule

// File: tb/tb_quotient_rx_bcd.sv
// Directed and randomised frames for quotient_rx_bcd, checked each cycle
// against a decimal-arithmetic reference of the expected report.
module tb_quotient_rx_bcd;

    localparam int BITS   = 10;
    localparam int DIGITS = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_data = 1'b0;
    logic        out_valid;
    logic [15:0] out_data;
    logic        out_div0;
    logic        out_err;

    quotient_rx_bcd #(.BITS(BITS), .DIGITS(DIGITS), .EXCESS(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_div0  (out_div0),
        .out_err   (out_err)
    );

    always #5 clk = ~clk;

    int          ncmp = 0;
    int          nfail = 0;
    bit          in_frame = 1'b0;
    int          nb = 0;
    longint unsigned val = 0;

    function automatic logic [15:0] ref_x3(input longint unsigned v);
        logic [15:0] r;
        r = '0;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'((v % 10) + 3);
            v = v / 10;
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [15:0] obs,
                         input logic [15:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic ev,
                             input logic [15:0] ed, input logic e0,
                             input logic ee);
        check({tag, ".valid"}, 16'(out_valid), 16'(ev));
        check({tag, ".data"},  out_data, ed);
        check({tag, ".div0"},  16'(out_div0), 16'(e0));
        check({tag, ".err"},   16'(out_err), 16'(ee));
    endtask

    // One clock: drive inputs at negedge, predict report, check after posedge.
    task automatic cycle(input bit vld, input bit b);
        logic        ev, e0, ee;
        logic [15:0] ed;
        @(negedge clk);
        in_valid = vld;
        in_data  = b;
        ev = 1'b0; e0 = 1'b0; ee = 1'b0; ed = '0;
        if (vld) begin
            if (!in_frame) begin
                in_frame = 1'b1;
                nb = 0;
                val = 0;
            end
            nb++;
            val = (val << 1) | longint'(b);
        end else if (in_frame) begin
            in_frame = 1'b0;
            if (nb == BITS) begin
                ev = 1'b1;
                ed = ref_x3(val);
                e0 = (val == (1 << BITS) - 1);
            end else begin
                ee = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        check_all("cyc", ev, ed, e0, ee);
    endtask

    task automatic frame(input int unsigned v, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            cycle(1'b1, 1'((v >> i) & 1));
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            cycle(1'b0, 1'($urandom));
        end
    endtask

    initial begin
        #1;
        check_all("reset", 1'b0, 16'h0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);

        // all-ones code, then reset asserted during its report cycle
        frame(1023, BITS);
        cycle(1'b0, 1'b0);
        check("div0_data", out_data, 16'h4356);
        #1;
        rst_n = 1'b0;
        #1;
        check_all("rst_report", 1'b0, 16'h0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        in_frame = 1'b0;
        idle(1);

        // reset mid-frame, then a clean frame
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'($urandom));
        #2;
        rst_n = 1'b0;
        #1;
        check_all("rst_mid", 1'b0, 16'h0, 1'b0, 1'b0);
        in_frame = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        in_valid = 1'b0;
        idle(1);
        frame(100, BITS);
        cycle(1'b0, 1'b0);
        check("d100", out_data, 16'h3433);
        idle(1);

        frame(0, BITS);
        idle(2);
        frame(999, BITS);
        cycle(1'b0, 1'b1);
        check("d999", out_data, 16'h3CCC);
        idle(1);

        // back-to-back with a single idle cycle
        frame(512, BITS);
        cycle(1'b0, 1'b1);
        check("d512", out_data, 16'h3845);
        frame(37, BITS);
        cycle(1'b0, 1'b0);
        check("d37", out_data, 16'h336A);
        idle(2);

        // length errors
        frame(7'h55, 7);
        idle(2);
        frame(12'hABC, 12);
        idle(2);
        frame(3, 1);
        idle(1);

        for (int k = 0; k < 2000; k++) begin
            frame($urandom_range(0, 1023), BITS);
            idle(int'($urandom_range(1, 6)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
